// File: rtl/bcd_counter_mux_disp_if.sv
// Control and display bus for bcd_counter_mux_disp.
// The master drives the control inputs and the slave (the counter) drives the count and display outputs.
interface bcd_counter_mux_disp_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic                      cnt_start;
   logic                      cnt_stop;
   logic                      cnt_rst;
   logic                      cnt_dir;
   logic                      disp_tgl;
   logic                      blank_lz;
   logic [4*NUM_DIGITS-1:0]   bcd_val;
   logic                      running;
   logic                      wrap;
   logic [6:0]                seg_out;
   logic [NUM_DIGITS-1:0]     dig_sel;

   modport master (
      output cnt_start, cnt_stop, cnt_rst, cnt_dir, disp_tgl, blank_lz,
      input  bcd_val, running, wrap, seg_out, dig_sel
   );

   modport slave (
      input  cnt_start, cnt_stop, cnt_rst, cnt_dir, disp_tgl, blank_lz,
      output bcd_val, running, wrap, seg_out, dig_sel
   );
endinterface

// File: rtl/bcd_counter_mux_disp.sv
// N-digit BCD up/down counter with terminal count, prescaler, start/stop/clear control
// and a time-multiplexed 7-segment display scanner.
module bcd_counter_mux_disp #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned MAX_VAL    = 9999,
   parameter int unsigned PRESCALE   = 1,
   parameter int unsigned SCAN_DIV   = 4
) (
   input logic                  clk,
   input logic                  rst,
   bcd_counter_mux_disp_if.slave io
);
   localparam int unsigned DW = 4 * NUM_DIGITS;
   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   function automatic logic [DW-1:0] to_bcd(input int unsigned v);
      logic [DW-1:0] r;
      int unsigned   t;
      r = '0;
      t = v;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] v);
      logic [DW-1:0] r;
      logic          c;
      r = v;
      c = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (c) begin
            if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
            else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
      logic [DW-1:0] r;
      logic          b;
      r = v;
      b = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (b) begin
            if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
            else begin
               r[4*i +: 4] = r[4*i +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   localparam logic [DW-1:0] MAX_BCD    = to_bcd(MAX_VAL);
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t                state, state_nxt;
   logic                  start_q, stop_q;
   logic                  start_e, stop_e;
   logic [PW-1:0]         presc, presc_nxt;
   logic [DW-1:0]         bcd_q, bcd_nxt;
   logic                  wrap_q, wrap_nxt;
   logic [SW-1:0]         scan, scan_nxt;
   logic [IW-1:0]         idx, idx_nxt;
   logic [6:0]            seg_q, seg_nxt;
   logic [NUM_DIGITS-1:0] sel_q, sel_nxt;
   logic [3:0]            digit;
   logic                  lead_zero;
   logic [6:0]            pattern;

   assign start_e = io.cnt_start & ~start_q;
   assign stop_e  = io.cnt_stop  & ~stop_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         start_q <= 1'b1;
         stop_q  <= 1'b1;
         presc   <= '0;
         bcd_q   <= '0;
         wrap_q  <= 1'b0;
         scan    <= '0;
         idx     <= '0;
         seg_q   <= '0;
         sel_q   <= NUM_DIGITS'(1);
      end else begin
         state   <= state_nxt;
         start_q <= io.cnt_start;
         stop_q  <= io.cnt_stop;
         presc   <= presc_nxt;
         bcd_q   <= bcd_nxt;
         wrap_q  <= wrap_nxt;
         scan    <= scan_nxt;
         idx     <= idx_nxt;
         seg_q   <= seg_nxt;
         sel_q   <= sel_nxt;
      end
   end

   // A stop edge in RUN freezes the prescaler and suppresses that cycle's step,
   // so PAUSE resumes with exactly the remaining clocks of the interrupted period.
   always_comb begin
      state_nxt = state;
      presc_nxt = presc;
      bcd_nxt   = bcd_q;
      wrap_nxt  = 1'b0;
      if (io.cnt_rst) begin
         state_nxt = IDLE;
         presc_nxt = '0;
         bcd_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               presc_nxt = '0;
               if (start_e && !stop_e) state_nxt = RUN;
            end
            RUN: begin
               if (stop_e) begin
                  state_nxt = PAUSE;
               end else if (presc == PRESC_LAST) begin
                  presc_nxt = '0;
                  if (io.cnt_dir) begin
                     if (bcd_q == MAX_BCD) begin
                        bcd_nxt  = '0;
                        wrap_nxt = 1'b1;
                     end else begin
                        bcd_nxt = bcd_inc(bcd_q);
                     end
                  end else begin
                     if (bcd_q == '0) begin
                        bcd_nxt  = MAX_BCD;
                        wrap_nxt = 1'b1;
                     end else begin
                        bcd_nxt = bcd_dec(bcd_q);
                     end
                  end
               end else begin
                  presc_nxt = presc + 1'b1;
               end
            end
            PAUSE: begin
               if (start_e && !stop_e) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      scan_nxt = scan + 1'b1;
      idx_nxt  = idx;
      if (scan == SCAN_LAST) begin
         scan_nxt = '0;
         idx_nxt  = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      digit     = bcd_q[4*idx_nxt +: 4];
      lead_zero = (idx_nxt != '0);
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (i >= 32'(idx_nxt) && bcd_q[4*i +: 4] != 4'd0) lead_zero = 1'b0;
      end
      pattern = (io.blank_lz && lead_zero) ? 7'h00 : seg7(digit);
      seg_nxt = pattern ^ {7{io.disp_tgl}};
      sel_nxt = '0;
      sel_nxt[idx_nxt] = 1'b1;
   end

   assign io.bcd_val = bcd_q;
   assign io.running = (state == RUN);
   assign io.wrap    = wrap_q;
   assign io.seg_out = seg_q;
   assign io.dig_sel = sel_q;
endmodule
